// File: rtl/inorder_pipe_core.sv
// inorder_pipe_core: 3-stage in-order core (Decode/Read, Execute, Writeback)
// with valid/ready handshakes, E->D operand forwarding and output back-pressure.
// Optional build macro STATUS_FLAGS_EN adds carry_flag/zero_flag outputs.
module inorder_pipe_core #(
    parameter int DATA_W     = 8,
    parameter int REG_ADDR_W = 3
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               instr_valid,
    output logic                               instr_ready,
    input  logic [3+3*REG_ADDR_W+DATA_W-1:0]   instruction,
    output logic                               result_valid,
    input  logic                               result_ready,
    output logic [DATA_W-1:0]                  result,
    output logic [REG_ADDR_W-1:0]              result_dst,
`ifdef STATUS_FLAGS_EN
    output logic                               carry_flag,
    output logic                               zero_flag,
`endif
    output logic                               busy
);

    localparam int NREGS   = 2**REG_ADDR_W;
    localparam int INSTR_W = 3 + 3*REG_ADDR_W + DATA_W;
    localparam int SHAMT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_LDI = 3'b110,
        OP_NOP = 3'b111
    } opcode_e;

    // Instruction fields, MSB first: {opcode, dst, srcA, srcB, imm}
    opcode_e               in_op;
    logic [REG_ADDR_W-1:0] in_dst;
    logic [REG_ADDR_W-1:0] in_srca;
    logic [REG_ADDR_W-1:0] in_srcb;
    logic [DATA_W-1:0]     in_imm;

    assign in_op   = opcode_e'(instruction[INSTR_W-1 -: 3]);
    assign in_dst  = instruction[INSTR_W-4 -: REG_ADDR_W];
    assign in_srca = instruction[INSTR_W-4-REG_ADDR_W -: REG_ADDR_W];
    assign in_srcb = instruction[INSTR_W-4-2*REG_ADDR_W -: REG_ADDR_W];
    assign in_imm  = instruction[DATA_W-1:0];

    // Register file
    logic [DATA_W-1:0] rf_q [NREGS];

    // Decode/Read stage
    logic                  dec_valid_q;
    opcode_e               dec_op_q;
    logic [REG_ADDR_W-1:0] dec_dst_q;
    logic [REG_ADDR_W-1:0] dec_srca_q;
    logic [REG_ADDR_W-1:0] dec_srcb_q;
    logic [DATA_W-1:0]     dec_imm_q;

    // Execute stage
    logic                  exe_valid_q;
    opcode_e               exe_op_q;
    logic [REG_ADDR_W-1:0] exe_dst_q;
    logic [DATA_W-1:0]     exe_a_q;
    logic [DATA_W-1:0]     exe_b_q;
    logic [DATA_W-1:0]     exe_imm_q;
    logic [DATA_W-1:0]     exe_a_d;
    logic [DATA_W-1:0]     exe_b_d;
    logic                  exe_writes;

    // Writeback / output stage
    logic                  result_valid_q;
    logic [DATA_W-1:0]     result_q;
    logic [REG_ADDR_W-1:0] result_dst_q;
    logic [DATA_W-1:0]     wb_result_d;

    logic                  advance;

    // The whole pipeline moves only when the output is not blocked.
    assign advance    = !(result_valid_q && !result_ready);
    assign exe_writes = exe_valid_q && (exe_op_q != OP_NOP);

    // An E-stage writer targeting a D-stage source supplies its ALU result
    // directly; W has already committed to the register file.
    assign exe_a_d = (exe_writes && (exe_dst_q == dec_srca_q)) ? wb_result_d : rf_q[dec_srca_q];
    assign exe_b_d = (exe_writes && (exe_dst_q == dec_srcb_q)) ? wb_result_d : rf_q[dec_srcb_q];

    // ALU: compute the E-stage result.
    always_comb begin
        // NOTE: default assignment first so no path leaves wb_result_d unassigned (no latch).
        wb_result_d = '0;
        case (exe_op_q)
            OP_ADD:  wb_result_d = exe_a_q + exe_b_q;
            OP_SUB:  wb_result_d = exe_a_q - exe_b_q;
            OP_AND:  wb_result_d = exe_a_q & exe_b_q;
            OP_OR:   wb_result_d = exe_a_q | exe_b_q;
            OP_XOR:  wb_result_d = exe_a_q ^ exe_b_q;
            OP_SHL:  wb_result_d = exe_a_q << exe_b_q[SHAMT_W-1:0];
            OP_LDI:  wb_result_d = exe_imm_q;
            default: wb_result_d = '0;
        endcase
    end

    // Register file write, committed on the same edge W is loaded.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the register file is architecturally cleared by reset, so it is a
            // flop array rather than a RAM macro; every entry must be reset here.
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (advance && exe_writes) begin
            // NOTE: non-blocking assignment so all stages sample pre-edge values.
            rf_q[exe_dst_q] <= wb_result_d;
        end
    end

    // Decode stage: capture an accepted instruction.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dec_valid_q <= 1'b0;
            dec_op_q    <= OP_ADD;
            dec_dst_q   <= '0;
            dec_srca_q  <= '0;
            dec_srcb_q  <= '0;
            dec_imm_q   <= '0;
        end else if (advance) begin
            dec_valid_q <= instr_valid;
            if (instr_valid) begin
                dec_op_q   <= in_op;
                dec_dst_q  <= in_dst;
                dec_srca_q <= in_srca;
                dec_srcb_q <= in_srcb;
                dec_imm_q  <= in_imm;
            end
        end
    end

    // Execute stage: latch operands (with forwarding) from D.
    always_ff @(posedge clk) begin
        if (!reset) begin
            exe_valid_q <= 1'b0;
            exe_op_q    <= OP_ADD;
            exe_dst_q   <= '0;
            exe_a_q     <= '0;
            exe_b_q     <= '0;
            exe_imm_q   <= '0;
        end else if (advance) begin
            exe_valid_q <= dec_valid_q;
            exe_op_q    <= dec_op_q;
            exe_dst_q   <= dec_dst_q;
            exe_a_q     <= exe_a_d;
            exe_b_q     <= exe_b_d;
            exe_imm_q   <= dec_imm_q;
        end
    end

    // Writeback stage: load the output register; NOPs and bubbles leave it empty.
    always_ff @(posedge clk) begin
        if (!reset) begin
            result_valid_q <= 1'b0;
            result_q       <= '0;
            result_dst_q   <= '0;
        end else if (advance) begin
            result_valid_q <= exe_writes;
            if (exe_writes) begin
                result_q     <= wb_result_d;
                result_dst_q <= exe_dst_q;
            end
        end
    end

`ifdef STATUS_FLAGS_EN
    logic              carry_d;
    logic              carry_q;
    logic              zero_q;
    logic [DATA_W:0]   sum_ext;

    assign sum_ext = {1'b0, exe_a_q} + {1'b0, exe_b_q};

    // Carry for ADD, borrow for SUB, otherwise clear.
    always_comb begin
        carry_d = 1'b0;
        case (exe_op_q)
            OP_ADD:  carry_d = sum_ext[DATA_W];
            OP_SUB:  carry_d = (exe_a_q < exe_b_q);
            default: carry_d = 1'b0;
        endcase
    end

    // Status flags track every result load.
    always_ff @(posedge clk) begin
        if (!reset) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else if (advance && exe_writes) begin
            carry_q <= carry_d;
            zero_q  <= (wb_result_d == '0);
        end
    end

    assign carry_flag = carry_q;
    assign zero_flag  = zero_q;
`endif

    assign instr_ready  = advance;
    assign result_valid = result_valid_q;
    assign result       = result_q;
    assign result_dst   = result_dst_q;
    assign busy         = dec_valid_q | exe_valid_q | result_valid_q;

endmodule

// File: tb/tb_inorder_pipe_core.sv
// Self-checking bench for inorder_pipe_core: directed scenarios plus a random
// stream, all results compared against an architectural (sequential) model.
// Build with STATUS_FLAGS_EN defined to also check carry_flag/zero_flag.
module tb_inorder_pipe_core;

    localparam int DW = 8;
    localparam int RA = 3;
    localparam int NR = 2**RA;
    localparam int IW = 3 + 3*RA + DW;

    logic          clk;
    logic          reset;
    logic          instr_valid;
    logic          instr_ready;
    logic [IW-1:0] instruction;
    logic          result_valid;
    logic          result_ready;
    logic [DW-1:0] result;
    logic [RA-1:0] result_dst;
    logic          busy;
`ifdef STATUS_FLAGS_EN
    logic          carry_flag;
    logic          zero_flag;
`endif

    inorder_pipe_core #(.DATA_W(DW), .REG_ADDR_W(RA)) dut (
        .clk          (clk),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instruction  (instruction),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .result_dst   (result_dst),
`ifdef STATUS_FLAGS_EN
        .carry_flag   (carry_flag),
        .zero_flag    (zero_flag),
`endif
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int val;
        int dst;
        int c;
        int z;
    } exp_t;

    exp_t exp_q[$];
    int   mregs[NR];
    int   total = 0;
    int   bad   = 0;
    int   out_cnt = 0;

    // Values sampled by the most recent cycle
    logic          rv_s;
    logic          ir_s;
    logic          busy_s;
    logic [DW-1:0] res_s;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [IW-1:0] enc(input int op, input int d, input int a, input int b, input int imm);
        logic [2:0]    o  = op[2:0];
        logic [RA-1:0] dd = d[RA-1:0];
        logic [RA-1:0] aa = a[RA-1:0];
        logic [RA-1:0] bb = b[RA-1:0];
        logic [DW-1:0] ii = imm[DW-1:0];
        return {o, dd, aa, bb, ii};
    endfunction

    // Architectural model: instructions execute one at a time in order.
    task automatic model_exec(input logic [IW-1:0] ins);
        int op, d, a, b, imm, v, c, s;
        int mask = (1 << DW) - 1;
        exp_t e;
        op  = int'(ins[IW-1 -: 3]);
        d   = int'(ins[IW-4 -: RA]);
        a   = mregs[int'(ins[IW-4-RA -: RA])];
        b   = mregs[int'(ins[IW-4-2*RA -: RA])];
        imm = int'(ins[DW-1:0]);
        c   = 0;
        v   = 0;
        case (op)
            0: begin s = a + b; v = s & mask; c = (s > mask) ? 1 : 0; end
            1: begin v = (a - b) & mask; c = (a < b) ? 1 : 0; end
            2: v = a & b;
            3: v = a | b;
            4: v = a ^ b;
            5: v = (a << (b % DW)) & mask;
            6: v = imm;
            default: v = 0;
        endcase
        if (op != 7) begin
            mregs[d] = v;
            e.val = v;
            e.dst = d;
            e.c   = c;
            e.z   = (v == 0) ? 1 : 0;
            exp_q.push_back(e);
        end
    endtask

    // One clock cycle: drive at negedge, sample, score handshakes, wait next negedge.
    task automatic cyc(input logic v, input logic [IW-1:0] ins, input logic rr, output logic fired);
        exp_t e;
        instr_valid  = v;
        instruction  = ins;
        result_ready = rr;
        #1;
        rv_s   = result_valid;
        ir_s   = instr_ready;
        busy_s = busy;
        res_s  = result;
        if (result_valid && rr) begin
            out_cnt++;
            check("pending_on_valid", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("result", result, e.val);
                check("result_dst", result_dst, e.dst);
`ifdef STATUS_FLAGS_EN
                check("carry_flag", carry_flag, e.c);
                check("zero_flag", zero_flag, e.z);
`endif
            end
        end
        fired = v && instr_ready;
        if (fired) model_exec(ins);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic f;
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b1, f);
    endtask

    task automatic send(input logic [IW-1:0] ins);
        logic f;
        cyc(1'b1, ins, 1'b1, f);
        check("send_accepted", f, 1'b1);
    endtask

    task automatic reset_core();
        instr_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        for (int i = 0; i < NR; i++) mregs[i] = 0;
        #1;
        check("rst_result", result, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_instr_ready", instr_ready, 1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic          f;
        int            base;
        int            idx;
        logic          rr;
        logic [IW-1:0] prog [4];
        int            b2b_vals [4];

        reset        = 1'b0;
        instr_valid  = 1'b0;
        instruction  = '0;
        result_ready = 1'b1;

        // Reset state, then ADD R3=R1+R2 on a cleared register file
        reset_core();
        base = out_cnt;
        send(enc(0, 3, 1, 2, 0));
        idle(4);
        check("rst_add_count", out_cnt - base, 1);

        // Back-to-back dependent instructions with forwarding, no stall
        prog[0] = enc(6, 1, 0, 0, 5);
        prog[1] = enc(6, 2, 0, 0, 3);
        prog[2] = enc(0, 3, 1, 2, 0);
        prog[3] = enc(1, 4, 2, 1, 0);
        b2b_vals = '{5, 3, 8, 254};
        for (int c = 0; c < 8; c++) begin
            cyc(c < 4, (c < 4) ? prog[c] : '0, 1'b1, f);
            if (c < 4) check("b2b_accept", f, 1'b1);
            check("b2b_ready", ir_s, 1'b1);
            check("b2b_valid", rv_s, (c >= 3 && c <= 6));
            if (c >= 3 && c <= 6) check("b2b_value", res_s, b2b_vals[c-3]);
        end

        // Back-pressure: six LDIs, consumer stalls for cycles 3..5
        base = out_cnt;
        idx  = 0;
        for (int i = 0; i < 20; i++) begin
            rr = !(i >= 3 && i <= 5);
            cyc(idx < 6, enc(6, idx + 1, 0, 0, idx + 1), rr, f);
            if (f) idx++;
            if (i >= 3 && i <= 5) begin
                check("bp_ready_low", ir_s, 1'b0);
                check("bp_valid_held", rv_s, 1'b1);
                check("bp_result_frozen", res_s, 1);
            end
        end
        check("bp_all_accepted", idx, 6);
        check("bp_all_emerged", out_cnt - base, 6);

        // NOP bubble: exactly two results
        base = out_cnt;
        send(enc(6, 5, 0, 0, 8'h0F));
        send(enc(7, 6, 0, 0, 8'hAA));
        send(enc(3, 6, 5, 0, 0));
        idle(6);
        check("nop_pulses", out_cnt - base, 2);

        // Reset with two instructions in flight
        send(enc(6, 5, 0, 0, 1));
        send(enc(6, 6, 0, 0, 2));
        #1;
        check("midrst_busy_before", busy, 1'b1);
        @(negedge clk);
        reset_core();
        base = out_cnt;
        idle(3);
        check("midrst_no_retire", out_cnt - base, 0);
        check("midrst_busy_after", busy_s, 1'b0);
        send(enc(0, 7, 5, 6, 0));
        idle(4);
        check("midrst_add_count", out_cnt - base, 1);

`ifdef STATUS_FLAGS_EN
        // Carry and zero flags
        send(enc(6, 1, 0, 0, 200));
        send(enc(6, 2, 0, 0, 100));
        send(enc(0, 3, 1, 2, 0));
        send(enc(1, 4, 3, 3, 0));
        idle(5);
`endif

        // Random stream with random consumer back-pressure
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(3, 0) != 0,
                enc($urandom_range(7, 0), $urandom_range(NR-1, 0), $urandom_range(NR-1, 0),
                    $urandom_range(NR-1, 0), $urandom_range(255, 0)),
                $urandom_range(9, 0) < 7, f);
        end
        idle(10);
        check("drain_pending", exp_q.size(), 0);
        check("drain_busy", busy_s, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inorder_pipe_core.md
Name: inorder_pipe_core

Overview:
Parametrised 3-stage in-order processor core: Decode/Read (D), Execute (E), Writeback (W). It replaces the earlier single-cycle core. New over that core: configurable data width and register count, valid/ready handshakes on input and output, full E→D operand forwarding, a load-immediate opcode and output back-pressure. It sits between the instruction source and the result consumer, one instruction per cycle when not stalled.

Parameters:
DATA_W, 8, datapath and register width; power of two, at least 4.
REG_ADDR_W, 3, register address width; register count NREGS = 2**REG_ADDR_W.
INSTR_W (localparam), 3+3*REG_ADDR_W+DATA_W, instruction width; 20 at defaults.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-low reset.
instr_valid  in  1  instruction present.
instr_ready  out  1  core can accept an instruction.
instruction  in  INSTR_W  {opcode[2:0], dst, srcA, srcB, imm[DATA_W-1:0]}, MSB first.
result_valid  out  1  result and result_dst are valid.
result_ready  in  1  consumer accepts the result.
result  out  DATA_W  written value.
result_dst  out  REG_ADDR_W  destination register of the result.
busy  out  1  any stage holds a valid instruction.

Behaviour:
- Reset (reset==0 at a clk edge): all NREGS registers, D/E/W pipeline registers and valid bits go to 0. result=0, result_dst=0, result_valid=0, busy=0. instr_ready=1 from the first cycle after reset. Reset overrides any in-flight instruction or stall; nothing in flight is retired.
- Opcodes:
  - 000 ADD: A+B.
  - 001 SUB: A-B, modulo 2**DATA_W.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SHL: A << B[$clog2(DATA_W)-1:0].
  - 110 LDI: imm.
  - 111 NOP: bubble; never writes and never raises result_valid.
- Pipeline advance: advance = !(result_valid && !result_ready). instr_ready = advance.
- Accept: on an edge with instr_valid && instr_ready, the instruction enters D. In D the register file is read for srcA/srcB.
- Latency: an instruction accepted at edge t has its result on the outputs with result_valid=1 after edge t+2, assuming no stall.
- Writeback: the register file is written at the same edge the E-stage result is loaded into the W/output register. The write happens only on an advancing edge and only for a valid non-NOP instruction.
- Forwarding: if the E-stage holds a valid writing instruction whose dst equals a D-stage srcA or srcB, the D-stage operand takes the E-stage ALU result instead of the register-file value. An instruction in W has already written the register file, so it needs no bypass. Back-to-back dependent instructions run with no stall.
- Stall: while advance==0, the D, E and W registers, the output and the register file all hold. result and result_dst stay stable until the handshake completes.
- Completion: on an edge with result_valid && result_ready, W takes the next E result, or clears result_valid if E is empty or holds a NOP.
- Simultaneous handshakes: input accept and output accept on the same edge are both legal and both take effect.
- Same-register read and write: srcA==srcB==dst is legal. Both operands use the pre-write value, or the forwarded value if a bypass applies.
- busy = valid_D | valid_E | result_valid.

Optional Feature:
STATUS_FLAGS_EN.
- Defined: adds output ports carry_flag (1) and zero_flag (1), reset to 0. Both update together with result on every W load.
- carry_flag: carry-out for ADD; borrow for SUB, i.e. 1 when A<B unsigned; 0 for all other opcodes.
- zero_flag: 1 when the loaded result == 0.
- Undefined: the ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Reset: drive reset=0 for 2 cycles, then 1 -> result=0, result_valid=0, busy=0, instr_ready=1. An ADD R3=R1+R2 then returns result=0, result_dst=3.
- Back-to-back dependency: send LDI R1=5, LDI R2=3, ADD R3=R1+R2, SUB R4=R2-R1 on consecutive cycles with result_ready=1.
  - Required: results 5, 3, 8, 254 on 4 consecutive cycles, starting 2 cycles after the first accept.
  - Required: no stall.
  - Required: R3=8, i.e. the E→D forward worked.
- Back-pressure: stream 6 LDIs with values 1..6 and hold result_ready=0 for cycles 3-5 -> instr_ready=0 during the hold, result frozen at value 1. Then 1..6 emerge in order with none lost or duplicated.
- NOP bubble: send LDI R5=0x0F, NOP, OR R6=R5|R0 -> exactly two result_valid pulses, values 0x0F and 0x0F. The NOP writes nothing.
- Reset mid-operation: assert reset while 2 instructions are in flight -> no result_valid afterwards, busy=0, and all registers read 0 (ADD R7=R5+R6 returns 0).
- STATUS_FLAGS_EN: LDI R1=200, LDI R2=100, ADD R3=R1+R2 -> result=44, carry_flag=1, zero_flag=0. Then SUB R4=R3-R3 -> result=0, carry_flag=0, zero_flag=1.
